spi_fifo_mm: RTL and testbench

Parametrised memory-mapped FIFO between the Avalon-style host bus and the SPI shift engine. The host pushes words through a data register. The SPI core pops words through a first-word-fall-through port. Status, sticky error flags, flush, programmable almost-full/almost-empty thresholds and a maskable interrupt are exposed through a 4-word register map. It succeeds the fixed 16x32 FIFO: depth, data width and thresholds are configurable, and concurrent push/pop is supported.

---
 rtl/spi_fifo_mm.sv | 156 +++++++++++++++
 tb/tb_spi_fifo_mm.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_fifo_mm.sv
// Memory-mapped FWFT FIFO between the host bus and the SPI shift engine.
// Host pushes through DATA, the core pops through PopData. STATUS, CTRL and THRESH hold flags, flush and thresholds.
module spi_fifo_mm #(
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 4,
  parameter int AF_DEFAULT = 12,
  parameter int AE_DEFAULT = 4
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              ChipSelect,
  input  logic [1:0]        Address,
  input  logic              Read,
  input  logic              Write,
  input  logic [31:0]       WriteData,
  output logic [31:0]       ReadData,
  input  logic              Pop,
  output logic [DATA_W-1:0] PopData,
  output logic              Empty,
  output logic              Full,
  output logic              Irq
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;

  typedef logic [DEPTH_LOG2-1:0] ptr_t;
  typedef logic [CW-1:0]         cnt_t;

  logic [DATA_W-1:0] mem_q [DEPTH];
  ptr_t        wp_q, wp_d, rp_q, rp_d;
  cnt_t        count_q, count_d;
  logic        ov_q, ov_d, uf_q, uf_d, irq_q, irq_d;
  logic [3:0]  irq_en_q, irq_en_d;
  logic [7:0]  af_q, af_d, ae_q, ae_d;
  logic [31:0] read_data_q, read_data_d;

  logic        rd_s, push_req_s, ctrl_wr_s, thr_wr_s, flush_s;
  logic        empty_s, full_s, pop_ok_s, push_ok_s, uf_set_s, ov_set_s;
  logic        ae_flag_s, af_flag_s;
  logic [31:0] status_s;

  assign rd_s       = ChipSelect & Read;
  assign push_req_s = ChipSelect & Write & (Address == 2'd0);
  assign ctrl_wr_s  = ChipSelect & Write & (Address == 2'd2);
  assign thr_wr_s   = ChipSelect & Write & (Address == 2'd3);
  assign flush_s    = ctrl_wr_s & WriteData[2];

  assign empty_s   = (count_q == cnt_t'(0));
  assign full_s    = (count_q == cnt_t'(DEPTH));
  assign ae_flag_s = (16'(count_q) <= 16'(ae_q));
  assign af_flag_s = (16'(count_q) >= 16'(af_q));

  // Flush swallows a same-cycle pop entirely; a pop at full frees the slot for a push.
  assign pop_ok_s  = Pop & ~empty_s & ~flush_s;
  assign uf_set_s  = Pop & empty_s & ~flush_s;
  assign push_ok_s = push_req_s & (~full_s | pop_ok_s);
  assign ov_set_s  = push_req_s & ~push_ok_s;

  assign status_s = (32'(count_q) << 5'd16) |
                    {26'd0, uf_q, ov_q, af_flag_s, ae_flag_s, full_s, empty_s};

  always_comb begin
    wp_d        = wp_q;
    rp_d        = rp_q;
    count_d     = count_q;
    ov_d        = ov_q;
    uf_d        = uf_q;
    irq_en_d    = irq_en_q;
    af_d        = af_q;
    ae_d        = ae_q;
    read_data_d = read_data_q;

    if (flush_s) begin
      wp_d    = ptr_t'(0);
      rp_d    = ptr_t'(0);
      count_d = cnt_t'(0);
    end else begin
      if (push_ok_s) wp_d = wp_q + ptr_t'(1);
      else           wp_d = wp_q;
      if (pop_ok_s)  rp_d = rp_q + ptr_t'(1);
      else           rp_d = rp_q;
      if (push_ok_s && !pop_ok_s)      count_d = count_q + cnt_t'(1);
      else if (pop_ok_s && !push_ok_s) count_d = count_q - cnt_t'(1);
      else                             count_d = count_q;
    end

    // Sticky set wins over a coincident write-1-to-clear.
    if (ov_set_s)                         ov_d = 1'b1;
    else if (ctrl_wr_s && WriteData[0])   ov_d = 1'b0;
    else                                  ov_d = ov_q;
    if (uf_set_s)                         uf_d = 1'b1;
    else if (ctrl_wr_s && WriteData[1])   uf_d = 1'b0;
    else                                  uf_d = uf_q;

    if (ctrl_wr_s) irq_en_d = WriteData[11:8];
    else           irq_en_d = irq_en_q;
    if (thr_wr_s) begin
      af_d = WriteData[23:16];
      ae_d = WriteData[7:0];
    end else begin
      af_d = af_q;
      ae_d = ae_q;
    end

    if (rd_s) begin
      case (Address)
        2'd0:    read_data_d = 32'd0;
        2'd1:    read_data_d = status_s;
        2'd2:    read_data_d = {20'd0, irq_en_q, 8'd0};
        2'd3:    read_data_d = {8'd0, af_q, 8'd0, ae_q};
        default: read_data_d = 32'd0;
      endcase
    end else begin
      read_data_d = read_data_q;
    end

    irq_d = |(irq_en_q & {ae_flag_s, af_flag_s, uf_q, ov_q});
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      wp_q        <= ptr_t'(0);
      rp_q        <= ptr_t'(0);
      count_q     <= cnt_t'(0);
      ov_q        <= 1'b0;
      uf_q        <= 1'b0;
      irq_q       <= 1'b0;
      irq_en_q    <= 4'd0;
      af_q        <= 8'(AF_DEFAULT);
      ae_q        <= 8'(AE_DEFAULT);
      read_data_q <= 32'd0;
    end else begin
      wp_q        <= wp_d;
      rp_q        <= rp_d;
      count_q     <= count_d;
      ov_q        <= ov_d;
      uf_q        <= uf_d;
      irq_q       <= irq_d;
      irq_en_q    <= irq_en_d;
      af_q        <= af_d;
      ae_q        <= ae_d;
      read_data_q <= read_data_d;
    end
  end

  // Storage has no reset; only pointers and count define its contents.
  always_ff @(posedge Clock) begin
    if (push_ok_s) mem_q[wp_q] <= WriteData[DATA_W-1:0];
  end

  assign PopData  = mem_q[rp_q];
  assign ReadData = read_data_q;
  assign Empty    = empty_s;
  assign Full     = full_s;
  assign Irq      = irq_q;
endmodule

// File: tb/tb_spi_fifo_mm.sv
// Scoreboard bench for spi_fifo_mm: a queue model of the FIFO plus shadow
// copies of the flags and registers predict every output.
module tb_spi_fifo_mm;
  logic        Clock = 1'b0;
  logic        Reset;
  logic        ChipSelect, Read, Write, Pop;
  logic [1:0]  Address;
  logic [31:0] WriteData, ReadData, PopData;
  logic        Empty, Full, Irq;

  int checks = 0;
  int failures = 0;

  logic [31:0] q[$];
  bit          m_ov, m_uf;
  logic [3:0]  m_ien;
  logic [7:0]  m_af, m_ae;
  logic [31:0] last_rd;

  spi_fifo_mm u_dut (
    .Clock(Clock), .Reset(Reset), .ChipSelect(ChipSelect), .Address(Address),
    .Read(Read), .Write(Write), .WriteData(WriteData), .ReadData(ReadData),
    .Pop(Pop), .PopData(PopData), .Empty(Empty), .Full(Full), .Irq(Irq)
  );

  always #5 Clock = ~Clock;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_status();
    int n = q.size();
    logic [31:0] s = 32'd0;
    s[0] = (n == 0);
    s[1] = (n == 16);
    s[2] = (n <= int'(m_ae));
    s[3] = (n >= int'(m_af));
    s[4] = m_ov;
    s[5] = m_uf;
    s[20:16] = 5'(n);
    return s;
  endfunction

  function automatic logic [31:0] m_read(input logic [1:0] addr);
    case (addr)
      2'd1:    return m_status();
      2'd2:    return {20'd0, m_ien, 8'd0};
      2'd3:    return {8'd0, m_af, 8'd0, m_ae};
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic m_irq();
    logic [31:0] s = m_status();
    return |(m_ien & {s[2], s[3], m_uf, m_ov});
  endfunction

  task automatic model_reset();
    q.delete();
    m_ov = 1'b0; m_uf = 1'b0; m_ien = 4'd0;
    m_af = 8'd12; m_ae = 8'd4; last_rd = 32'd0;
  endtask

  // One bus/core cycle: predict, drive, let the edge pass, compare.
  task automatic step(input bit wr, input bit rd, input logic [1:0] addr,
                      input logic [31:0] wdata, input bit pop);
    int n;
    bit flush, push_req, pop_ok, push_ok, uf_set, ov_set;
    logic exp_irq;
    logic [31:0] exp_rd;
    ChipSelect = wr | rd; Write = wr; Read = rd; Address = addr;
    WriteData = wdata; Pop = pop;
    #1;
    n        = q.size();
    flush    = wr && addr == 2'd2 && wdata[2];
    push_req = wr && addr == 2'd0;
    pop_ok   = pop && n != 0 && !flush;
    uf_set   = pop && n == 0 && !flush;
    push_ok  = push_req && (n < 16 || pop_ok);
    ov_set   = push_req && !push_ok;
    exp_irq  = m_irq();
    exp_rd   = rd ? m_read(addr) : last_rd;
    if (pop_ok) check("pop_data", PopData, q.pop_front());
    if (push_ok) q.push_back(wdata);
    if (flush) q.delete();
    if (ov_set) m_ov = 1'b1;
    else if (wr && addr == 2'd2 && wdata[0]) m_ov = 1'b0;
    if (uf_set) m_uf = 1'b1;
    else if (wr && addr == 2'd2 && wdata[1]) m_uf = 1'b0;
    if (wr && addr == 2'd2) m_ien = wdata[11:8];
    if (wr && addr == 2'd3) begin
      m_af = wdata[23:16];
      m_ae = wdata[7:0];
    end
    @(posedge Clock);
    #1;
    ChipSelect = 1'b0; Write = 1'b0; Read = 1'b0; Pop = 1'b0;
    last_rd = exp_rd;
    check("irq", {31'd0, Irq}, {31'd0, exp_irq});
    check("read_data", ReadData, exp_rd);
    check("empty", {31'd0, Empty}, {31'd0, q.size() == 0});
    check("full", {31'd0, Full}, {31'd0, q.size() == 16});
  endtask

  task automatic push(input logic [31:0] d); step(1'b1, 1'b0, 2'd0, d, 1'b0); endtask
  task automatic pop1();                     step(1'b0, 1'b0, 2'd0, 32'd0, 1'b1); endtask
  task automatic rd(input logic [1:0] a);    step(1'b0, 1'b1, a, 32'd0, 1'b0); endtask
  task automatic wr(input logic [1:0] a, input logic [31:0] d); step(1'b1, 1'b0, a, d, 1'b0); endtask

  initial begin
    Reset = 1'b1; ChipSelect = 1'b0; Read = 1'b0; Write = 1'b0; Pop = 1'b0;
    Address = 2'd0; WriteData = 32'd0;
    model_reset();
    #12;
    check("rst_read_data", ReadData, 32'd0);
    check("rst_empty", {31'd0, Empty}, 32'd1);
    check("rst_full", {31'd0, Full}, 32'd0);
    check("rst_irq", {31'd0, Irq}, 32'd0);
    Reset = 1'b0;
    @(posedge Clock); #1;

    // Basic ordering and FWFT head.
    for (int i = 1; i <= 3; i++) push(32'hA5A5_0000 + 32'(i));
    rd(2'd1);
    check("status_cnt3", ReadData, 32'h0003_0004);
    check("fwft_head", PopData, 32'hA5A5_0001);
    for (int i = 0; i < 3; i++) pop1();
    rd(2'd2); rd(2'd3);

    // Overflow at full, clear, push+pop at full.
    for (int i = 0; i < 16; i++) push($urandom);
    push(32'h0000_DEAD);
    rd(2'd1);
    check("status_ov", ReadData, 32'h0010_001A);
    wr(2'd2, 32'h1);
    rd(2'd1);
    step(1'b1, 1'b0, 2'd0, 32'h5EED_0000, 1'b1);
    rd(2'd1);
    check("status_full_pp", ReadData, 32'h0010_000A);
    for (int i = 0; i < 16; i++) pop1();

    // Underflow, interrupt, sticky set beating clear.
    pop1();
    rd(2'd1);
    wr(2'd2, 32'h200);
    step(1'b0, 1'b0, 2'd0, 32'd0, 1'b0);
    check("irq_uf", {31'd0, Irq}, 32'd1);
    step(1'b1, 1'b0, 2'd2, 32'h202, 1'b1);
    rd(2'd1);
    wr(2'd2, 32'h202);
    step(1'b0, 1'b0, 2'd0, 32'd0, 1'b0);
    check("irq_uf_clr", {31'd0, Irq}, 32'd0);

    // Programmable thresholds.
    wr(2'd3, 32'h0003_0001);
    wr(2'd2, 32'h400);
    for (int i = 0; i < 3; i++) push(32'h7000_0000 + 32'(i));
    rd(2'd1);
    step(1'b0, 1'b0, 2'd0, 32'd0, 1'b0);
    check("irq_af", {31'd0, Irq}, 32'd1);
    pop1(); pop1();
    rd(2'd1);
    check("status_ae", ReadData, 32'h0001_0004);
    rd(2'd3);

    // Streaming through many pointer wraps, then flush with a same-cycle pop.
    for (int i = 0; i < 40; i++) step(1'b1, 1'b0, 2'd0, $urandom, q.size() > 2);
    for (int i = 0; i < 20; i++) step($urandom_range(0, 1) == 1, 1'b0, 2'd0, $urandom, $urandom_range(0, 1) == 1);
    while (q.size() < 3) push($urandom);
    while (q.size() > 3) pop1();
    step(1'b1, 1'b0, 2'd2, 32'h4, 1'b1);
    rd(2'd1);
    check("status_flush", ReadData[21:16], 6'd0);
    check("flush_uf", {31'd0, ReadData[5]}, 32'd0);

    // Asynchronous reset mid-stream with a push in flight.
    wr(2'd3, 32'h000C_0004);
    wr(2'd2, 32'h100);
    for (int i = 0; i < 5; i++) push(32'hB000_0000 + 32'(i));
    rd(2'd1);
    ChipSelect = 1'b1; Write = 1'b1; Address = 2'd0; WriteData = 32'hBAD0_BAD0;
    #2;
    Reset = 1'b1;
    #1;
    check("mid_rst_empty", {31'd0, Empty}, 32'd1);
    check("mid_rst_full", {31'd0, Full}, 32'd0);
    check("mid_rst_irq", {31'd0, Irq}, 32'd0);
    check("mid_rst_read_data", ReadData, 32'd0);
    ChipSelect = 1'b0; Write = 1'b0;
    model_reset();
    #3;
    Reset = 1'b0;
    @(posedge Clock); #1;
    rd(2'd1);
    check("post_rst_status", ReadData, 32'h0000_0005);
    push(32'hC0DE_0001);
    pop1();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
